// File: rtl/ls_counter_n_if.sv
// Control and status bundle for ls_counter_n. The master drives the controls and the slave is the counter.
// The cmp/match pair exists only when LS_COUNTER_MATCH_EN is defined.
interface ls_counter_n_if #(
  parameter int unsigned WIDTH = 4
);
  logic             sr_b;
  logic             pe_b;
  logic [WIDTH-1:0] p;
  logic             cep;
  logic             cet;
  logic             up;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrap;
`ifdef LS_COUNTER_MATCH_EN
  logic [WIDTH-1:0] cmp;
  logic             match;

  modport master (
    output sr_b, pe_b, p, cep, cet, up, cmp,
    input  q, tc, wrap, match
  );

  modport slave (
    input  sr_b, pe_b, p, cep, cet, up, cmp,
    output q, tc, wrap, match
  );
`else
  modport master (
    output sr_b, pe_b, p, cep, cet, up,
    input  q, tc, wrap
  );

  modport slave (
    input  sr_b, pe_b, p, cep, cet, up,
    output q, tc, wrap
  );
`endif
endinterface

// File: rtl/ls_counter_n.sv
// Parametrised 163-style up/down counter with a cascadable tc and a registered wrap pulse.
// Defining LS_COUNTER_MATCH_EN adds the registered cmp/match compare.
module ls_counter_n #(
  parameter int unsigned      WIDTH = 4,
  parameter logic [WIDTH-1:0] MAX   = {WIDTH{1'b1}}
) (
  input logic          cp,
  input logic          mr_b,
  ls_counter_n_if.slave bus
);

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  logic [WIDTH-1:0] q_reg;
  logic             wrap_reg;
  logic             over_range;
  logic             at_top;
  logic             at_bottom;
  logic             count_en;
  logic [WIDTH-1:0] step_q;
  logic             step_wraps;

  // A full-range MAX means no out-of-range value can be loaded.
  generate
    if (MAX == ALL_ONES) begin : g_full_range
      assign over_range = 1'b0;
    end else begin : g_part_range
      assign over_range = (q_reg > MAX);
    end
  endgenerate

  assign at_top    = (q_reg == MAX);
  assign at_bottom = (q_reg == '0);
  assign count_en  = bus.cep & bus.cet;

  always_comb begin
    step_q     = q_reg;
    step_wraps = 1'b0;
    if (bus.up) begin
      if (over_range || at_top) begin
        step_q = '0;
      end else begin
        step_q = q_reg + ONE;
      end
      step_wraps = at_top;
    end else begin
      // An out-of-range value snaps to MAX but is not a wrap.
      if (over_range || at_bottom) begin
        step_q = MAX;
      end else begin
        step_q = q_reg - ONE;
      end
      step_wraps = at_bottom;
    end
  end

  always_ff @(posedge cp or negedge mr_b) begin
    if (!mr_b) begin
      q_reg    <= '0;
      wrap_reg <= 1'b0;
    end else begin
      wrap_reg <= 1'b0;
      if (!bus.sr_b) begin
        q_reg <= '0;
      end else if (!bus.pe_b) begin
        q_reg <= bus.p;
      end else if (count_en) begin
        q_reg    <= step_q;
        wrap_reg <= step_wraps;
      end
    end
  end

  assign bus.q    = q_reg;
  assign bus.wrap = wrap_reg;
  assign bus.tc   = bus.cet & (bus.up ? at_top : at_bottom);

`ifdef LS_COUNTER_MATCH_EN
  logic match_reg;

  // Only a count step can raise match, so moving cmp onto the current q is ignored.
  always_ff @(posedge cp or negedge mr_b) begin
    if (!mr_b) begin
      match_reg <= 1'b0;
    end else begin
      match_reg <= bus.sr_b & bus.pe_b & count_en & (step_q == bus.cmp);
    end
  end

  assign bus.match = match_reg;
`endif

endmodule

// File: tb/tb_ls_counter_n.sv
// Directed bench for ls_counter_n: a MAX=9 decade counter plus a two-stage 8-bit cascade.
// Match checks run when LS_COUNTER_MATCH_EN is defined.
module tb_ls_counter_n;

  logic cp;
  logic mr_b;
  int   checks;
  int   failures;

  ls_counter_n_if #(.WIDTH(4)) dec_bus ();
  ls_counter_n_if #(.WIDTH(4)) lo_bus ();
  ls_counter_n_if #(.WIDTH(4)) hi_bus ();

  ls_counter_n #(.WIDTH(4), .MAX(4'd9)) u_dec (.cp(cp), .mr_b(mr_b), .bus(dec_bus));
  ls_counter_n #(.WIDTH(4))             u_lo  (.cp(cp), .mr_b(mr_b), .bus(lo_bus));
  ls_counter_n #(.WIDTH(4))             u_hi  (.cp(cp), .mr_b(mr_b), .bus(hi_bus));

  assign hi_bus.cet = lo_bus.tc;

  initial cp = 1'b0;
  always #5 cp = ~cp;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic sr_b, input logic pe_b, input logic [3:0] p,
                               input logic cep, input logic cet, input logic up);
    dec_bus.sr_b = sr_b;
    dec_bus.pe_b = pe_b;
    dec_bus.p    = p;
    dec_bus.cep  = cep;
    dec_bus.cet  = cet;
    dec_bus.up   = up;
  endtask

  task automatic tick();
    @(posedge cp);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    mr_b     = 1'b0;
    applyStimulus(1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1);
    lo_bus.sr_b = 1'b1; lo_bus.pe_b = 1'b1; lo_bus.p = 4'd0;
    lo_bus.cep  = 1'b0; lo_bus.cet  = 1'b0; lo_bus.up = 1'b1;
    hi_bus.sr_b = 1'b1; hi_bus.pe_b = 1'b1; hi_bus.p = 4'd0;
    hi_bus.cep  = 1'b0; hi_bus.up   = 1'b1;
`ifdef LS_COUNTER_MATCH_EN
    dec_bus.cmp = 4'd15;
    lo_bus.cmp  = 4'd0;
    hi_bus.cmp  = 4'd0;
`endif
    #12;
    checkOutput("reset_q", 32'(dec_bus.q), 32'd0);
    checkOutput("reset_wrap", 32'(dec_bus.wrap), 32'd0);
    mr_b = 1'b1;

    // Count to 9, then assert reset between edges.
    applyStimulus(1'b1, 1'b1, 4'd0, 1'b1, 1'b1, 1'b1);
    repeat (9) tick();
    checkOutput("count_to_9", 32'(dec_bus.q), 32'd9);
    #2 mr_b = 1'b0;
    #1;
    checkOutput("async_reset_q", 32'(dec_bus.q), 32'd0);
    checkOutput("async_reset_wrap", 32'(dec_bus.wrap), 32'd0);
    #2 mr_b = 1'b1;
    tick();
    checkOutput("first_after_reset", 32'(dec_bus.q), 32'd1);

    // Up wrap through MAX=9.
    applyStimulus(1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 1'b1);
    tick();
    checkOutput("clear_q", 32'(dec_bus.q), 32'd0);
    applyStimulus(1'b1, 1'b1, 4'd0, 1'b1, 1'b1, 1'b1);
    for (int i = 1; i <= 10; i++) begin
      tick();
      checkOutput("up_q", 32'(dec_bus.q), 32'(i % 10));
      checkOutput("up_tc", 32'(dec_bus.tc), (i == 9) ? 32'd1 : 32'd0);
      checkOutput("up_wrap", 32'(dec_bus.wrap), (i == 10) ? 32'd1 : 32'd0);
    end
    tick();
    checkOutput("up_after_wrap_q", 32'(dec_bus.q), 32'd1);
    checkOutput("up_wrap_one_cycle", 32'(dec_bus.wrap), 32'd0);

    // Down count across zero.
    applyStimulus(1'b1, 1'b0, 4'd1, 1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("down_load_q", 32'(dec_bus.q), 32'd1);
    checkOutput("down_load_tc", 32'(dec_bus.tc), 32'd0);
    applyStimulus(1'b1, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("down_q0", 32'(dec_bus.q), 32'd0);
    checkOutput("down_tc0", 32'(dec_bus.tc), 32'd1);
    checkOutput("down_wrap0", 32'(dec_bus.wrap), 32'd0);
    dec_bus.up = 1'b1;
    #1;
    checkOutput("tc_follows_up", 32'(dec_bus.tc), 32'd0);
    dec_bus.up = 1'b0;
    #1;
    tick();
    checkOutput("down_q9", 32'(dec_bus.q), 32'd9);
    checkOutput("down_tc9", 32'(dec_bus.tc), 32'd0);
    checkOutput("down_wrap9", 32'(dec_bus.wrap), 32'd1);
    tick();
    checkOutput("down_q8", 32'(dec_bus.q), 32'd8);
    checkOutput("down_wrap8", 32'(dec_bus.wrap), 32'd0);

    // cet gates tc and both enables hold the count.
    applyStimulus(1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("cet0_tc", 32'(dec_bus.tc), 32'd0);
    repeat (5) tick();
    checkOutput("cet0_hold", 32'(dec_bus.q), 32'd0);
    applyStimulus(1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0);
    #1;
    checkOutput("cep0_tc", 32'(dec_bus.tc), 32'd1);
    repeat (5) tick();
    checkOutput("cep0_hold", 32'(dec_bus.q), 32'd0);

    // Clear beats load; loads never raise wrap.
    applyStimulus(1'b1, 1'b0, 4'd5, 1'b1, 1'b1, 1'b1);
    tick();
    checkOutput("prio_load5", 32'(dec_bus.q), 32'd5);
    applyStimulus(1'b0, 1'b0, 4'd7, 1'b1, 1'b1, 1'b1);
    tick();
    checkOutput("prio_clear_q", 32'(dec_bus.q), 32'd0);
    checkOutput("prio_clear_wrap", 32'(dec_bus.wrap), 32'd0);
    applyStimulus(1'b1, 1'b0, 4'd7, 1'b1, 1'b1, 1'b1);
    tick();
    checkOutput("prio_load7", 32'(dec_bus.q), 32'd7);
    applyStimulus(1'b1, 1'b0, 4'd9, 1'b1, 1'b1, 1'b1);
    tick();
    checkOutput("load_max_q", 32'(dec_bus.q), 32'd9);
    checkOutput("load_max_wrap", 32'(dec_bus.wrap), 32'd0);
    applyStimulus(1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1);
    tick();
    checkOutput("load_zero_wrap", 32'(dec_bus.wrap), 32'd0);

    // Out-of-range loads normalise on the next count step.
    applyStimulus(1'b1, 1'b0, 4'd12, 1'b1, 1'b1, 1'b1);
    tick();
    checkOutput("oor_load_q", 32'(dec_bus.q), 32'd12);
    checkOutput("oor_tc", 32'(dec_bus.tc), 32'd0);
    applyStimulus(1'b1, 1'b1, 4'd0, 1'b1, 1'b1, 1'b1);
    tick();
    checkOutput("oor_up_q", 32'(dec_bus.q), 32'd0);
    checkOutput("oor_up_wrap", 32'(dec_bus.wrap), 32'd0);
    applyStimulus(1'b1, 1'b0, 4'd12, 1'b1, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("oor_down_q", 32'(dec_bus.q), 32'd9);
    checkOutput("oor_down_wrap", 32'(dec_bus.wrap), 32'd0);

`ifdef LS_COUNTER_MATCH_EN
    applyStimulus(1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 1'b1);
    dec_bus.cmp = 4'd6;
    tick();
    checkOutput("match_clear", 32'(dec_bus.match), 32'd0);
    applyStimulus(1'b1, 1'b1, 4'd0, 1'b1, 1'b1, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      tick();
      checkOutput("match_step", 32'(dec_bus.match), (i == 6) ? 32'd1 : 32'd0);
    end
    applyStimulus(1'b1, 1'b0, 4'd6, 1'b1, 1'b1, 1'b1);
    tick();
    checkOutput("match_load_q", 32'(dec_bus.q), 32'd6);
    checkOutput("match_load", 32'(dec_bus.match), 32'd0);
    applyStimulus(1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1);
    dec_bus.cmp = 4'd6;
    tick();
    checkOutput("match_hold", 32'(dec_bus.match), 32'd0);
`endif

    // Two-stage cascade, low tc driving high cet.
    applyStimulus(1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1);
    lo_bus.sr_b = 1'b0; hi_bus.sr_b = 1'b0;
    tick();
    checkOutput("casc_clear", 32'({hi_bus.q, lo_bus.q}), 32'd0);
    lo_bus.sr_b = 1'b1; hi_bus.sr_b = 1'b1;
    lo_bus.cep  = 1'b1; lo_bus.cet  = 1'b1; hi_bus.cep = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      tick();
      checkOutput("casc_q", 32'({hi_bus.q, lo_bus.q}), 32'(i % 256));
      checkOutput("casc_lo_wrap", 32'(lo_bus.wrap), ((i % 16) == 0) ? 32'd1 : 32'd0);
      checkOutput("casc_hi_wrap", 32'(hi_bus.wrap), (i == 256) ? 32'd1 : 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ls_counter_n.md
Name: ls_counter_n

Overview:
- Parametrised synchronous binary counter. Next generation of the team's 4-bit 74LS163A-style counter.
- Generalises width and terminal value, and adds up/down direction and a registered wrap pulse.
- Keeps 163-style parallel load and CEP/CET cascade enables.
- Used for the timer/divider chains and the PPU/DMA address counters; instances cascade through tc -> cet.

Parameters:
- WIDTH, 4: counter width in bits (1..32).
- MAX, 2**WIDTH-1: terminal value. Counting up wraps MAX->0; counting down wraps 0->MAX. Must be <= 2**WIDTH-1.

Ports:
- cp  input  1  clock, rising edge.
- mr_b  input  1  asynchronous active-low master reset.
- sr_b  input  1  synchronous active-low clear.
- pe_b  input  1  synchronous active-low parallel load.
- p  input  WIDTH  parallel load data.
- cep  input  1  count enable, parallel.
- cet  input  1  count enable, trickle; also gates tc.
- up  input  1  direction: 1 = up, 0 = down.
- q  output  WIDTH  current count.
- tc  output  1  terminal count, combinational.
- wrap  output  1  registered one-cycle pulse, high the cycle after a counting wrap.

Behaviour:
- Reset: mr_b low forces q=0 and wrap=0 immediately, independent of cp. Reset may assert mid-count. Counting resumes on the first rising cp after mr_b deasserts. No state survives reset.
- Synchronous priority at each rising cp, highest first:
  1. sr_b=0 -> q<=0.
  2. pe_b=0 -> q<=p.
  3. cep&cet=1 -> count one step.
  4. Otherwise hold.
- Count step, up=1: q==MAX ? 0 : q+1. If q>MAX (loaded out of range), q<=0.
- Count step, down=0: q==0 ? MAX : q-1. If q>MAX, q<=MAX.
- Out-of-range load: p is loaded unmodified even if p>MAX; the next count step normalises it as above.
- tc = cet & (up ? q==MAX : q==0).
  - Combinational, no cep term, so a cascade stage enables the next via cet.
  - tc follows up changes in the same cycle.
- wrap:
  - Set to 1 for exactly one cycle after an edge where a count step took q from MAX to 0 (up) or from 0 to MAX (down).
  - Otherwise 0.
  - Clear and load never raise wrap, even if they produce 0 or MAX.
- Simultaneous sr_b=0 and pe_b=0: clear wins, no wrap.
- Direction reversal: takes effect on the same edge, with no idle cycle.
- Latency: q changes on the edge where its control was sampled. wrap lags the wrap step by one edge.
- WIDTH=1 with MAX=1 is a legal toggle flip-flop. MAX=0: q stays 0; every count step is a wrap.

Optional Feature:
- Macro: LS_COUNTER_MATCH_EN.
- Defined:
  - Adds input cmp [WIDTH] and output match [1].
  - match is registered. It is high for one cycle after any edge where a count step (not a load or clear) makes q equal cmp.
  - Reset value of match is 0.
  - If cmp changes while q already equals it, match is not raised.
- Undefined: cmp and match ports are absent and no compare logic is built.

Test Plan:
- Reset: WIDTH=4, count to 9, pulse mr_b low between edges -> q=0 and wrap=0 immediately. First edge after release with cep=cet=up=1 -> q=1.
- Up wrap: WIDTH=4, MAX=9, up=1, cep=cet=1 from 0 for 10 edges.
  - q = 1..9 then 0.
  - tc=1 only while q=9.
  - wrap=1 exactly in the cycle after q returns to 0.
- Down wrap and tc: MAX=9, load p=1, up=0 -> q=1,0,9,8.
  - tc=1 only while q=0.
  - wrap=1 the cycle q shows 9.
  - With cet=0, tc=0 and q holds.
- Priority: q=5, sr_b=0 with pe_b=0 and p=7 -> q=0, no wrap. Next edge with pe_b=0 only -> q=7. Load of p=9 with MAX=9 -> wrap stays 0.
- Out-of-range and enables:
  - MAX=9, load p=12, up=1 count -> q=0. Load p=12, up=0 count -> q=9.
  - cep=0 or cet=0 holds q across 5 edges.
- Cascade: two WIDTH=4 instances, low tc -> high cet, both cep=1 -> 8-bit count 0x0F->0x10 on one edge, 0xFF->0x00. Low wrap pulses every 16 counts; high wrap pulses once.
- Match, macro defined: cmp=6, count up from 0 -> match=1 the cycle after q=6, for one cycle. Load p=6 -> match stays 0.
